// File: rtl/output_deskewer.sv
// Deskews the systolic array's output stream: lane i is delayed so every lane of a
// result row leaves on the same cycle, rows are counted and lane misalignment is flagged.
//
// state   | meaning
// IDLE    | waiting for the first aligned row of a result matrix
// COLLECT | first row seen, counting rows until the last one of the matrix
module output_deskewer #(
    parameter int MATRIX_SIZE = 4,
    parameter int DATA_SIZE   = 32
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    enable_in,
    input  logic                                    clear,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]   data_skewed,
    input  logic [MATRIX_SIZE-1:0]                  valid_skewed,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]   data_aligned,
    output logic                                    valid_out,
    output logic [$clog2(MATRIX_SIZE)-1:0]          row_idx,
    output logic                                    done,
    output logic                                    err_misalign
);

    localparam int IDX_W = $clog2(MATRIX_SIZE);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(MATRIX_SIZE - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    logic [MATRIX_SIZE-1:0]                  av;
    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]   ad;
    logic                                    row_ok;
    logic                                    row_mix;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   row_idx_nxt;
    logic               done_nxt;

    // Lane i waits MATRIX_SIZE-1-i cycles; the last lane feeds the output register directly.
    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
        localparam int DEPTH = MATRIX_SIZE - 1 - i;
        if (DEPTH == 0) begin : g_pass
            assign av[i] = valid_skewed[i];
            assign ad[i] = data_skewed[i];
        end else begin : g_dly
            logic [DEPTH-1:0]                v_sr;
            logic [DEPTH-1:0][DATA_SIZE-1:0] d_sr;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    v_sr <= '0;
                    d_sr <= '0;
                end else if (enable_in) begin
                    v_sr[0] <= valid_skewed[i];
                    d_sr[0] <= data_skewed[i];
                    for (int k = 1; k < DEPTH; k++) begin
                        v_sr[k] <= v_sr[k-1];
                        d_sr[k] <= d_sr[k-1];
                    end
                end
            end

            assign av[i] = v_sr[DEPTH-1];
            assign ad[i] = d_sr[DEPTH-1];
        end
    end

    assign row_ok  = &av;
    assign row_mix = (|av) & ~row_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_aligned <= '0;
            valid_out    <= 1'b0;
        end else if (enable_in) begin
            data_aligned <= ad;
            valid_out    <= row_ok;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_misalign <= 1'b0;
        end else if (clear) begin
            err_misalign <= 1'b0;
        end else if (enable_in && row_mix) begin
            err_misalign <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            row_idx <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            row_idx <= row_idx_nxt;
            done    <= done_nxt;
        end
    end

    // cnt is the index the next accepted row will carry; row_idx labels the row now on the output.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        row_idx_nxt = row_idx;
        done_nxt    = done;
        if (clear) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            row_idx_nxt = '0;
            done_nxt    = 1'b0;
        end else if (!enable_in) begin
            done_nxt = 1'b0;
        end else begin
            done_nxt = 1'b0;
            if (row_ok) begin
                case (state)
                    IDLE: begin
                        row_idx_nxt = '0;
                        cnt_nxt     = IDX_W'(1);
                        state_nxt   = COLLECT;
                    end
                    COLLECT: begin
                        row_idx_nxt = cnt;
                        if (cnt == LAST_ROW) begin
                            done_nxt  = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_output_deskewer.sv
// Directed bench for output_deskewer (4 lanes x 32 bits): skewed rows are scheduled per
// enabled cycle and the aligned outputs are compared against hand-derived values.
module tb_output_deskewer;

    localparam int MS = 4;
    localparam int DS = 32;

    logic                      clk;
    logic                      reset;
    logic                      enable_in;
    logic                      clear;
    logic [MS-1:0][DS-1:0]     data_skewed;
    logic [MS-1:0]             valid_skewed;
    logic [MS-1:0][DS-1:0]     data_aligned;
    logic                      valid_out;
    logic [1:0]                row_idx;
    logic                      done;
    logic                      err_misalign;

    output_deskewer #(.MATRIX_SIZE(MS), .DATA_SIZE(DS)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_in    (enable_in),
        .clear        (clear),
        .data_skewed  (data_skewed),
        .valid_skewed (valid_skewed),
        .data_aligned (data_aligned),
        .valid_out    (valid_out),
        .row_idx      (row_idx),
        .done         (done),
        .err_misalign (err_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ptr      = 0;

    logic [DS-1:0] sd [0:63][0:MS-1];
    logic          sv [0:63][0:MS-1];

    task automatic chk_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] row_val(input logic [31:0] base);
        logic [127:0] r;
        for (int i = 0; i < MS; i++) r[i*32 +: 32] = base + 32'(i);
        return r;
    endfunction

    task automatic clr_sched();
        for (int c = 0; c < 64; c++)
            for (int i = 0; i < MS; i++) begin
                sd[c][i] = '0;
                sv[c][i] = 1'b0;
            end
        ptr = 0;
    endtask

    task automatic put_row(input int t, input logic [31:0] base);
        for (int i = 0; i < MS; i++) begin
            sd[t+i][i] = base + 32'(i);
            sv[t+i][i] = 1'b1;
        end
    endtask

    // Stalled cycles drive all-valid junk that must be ignored.
    task automatic tick(input logic en);
        enable_in = en;
        for (int i = 0; i < MS; i++) begin
            if (en) begin
                data_skewed[i]  = sd[ptr][i];
                valid_skewed[i] = sv[ptr][i];
            end else begin
                data_skewed[i]  = 32'hDEAD_0000 + 32'(i);
                valid_skewed[i] = 1'b1;
            end
        end
        if (en) ptr++;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input string tag, input logic v, input logic [31:0] base,
                           input int idx, input logic dn);
        chk_val({tag, ".valid"}, 128'(valid_out), 128'(v));
        chk_val({tag, ".done"}, 128'(done), 128'(dn));
        if (v) begin
            chk_val({tag, ".data"}, data_aligned, row_val(base));
            chk_val({tag, ".idx"}, 128'(row_idx), 128'(idx));
        end
    endtask

    initial begin
        reset        = 1'b0;
        enable_in    = 1'b1;
        clear        = 1'b0;
        data_skewed  = {MS{32'hFFFF_FFFF}};
        valid_skewed = '1;
        clr_sched();

        // reset holds everything at zero despite active inputs
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_val("rst.data", data_aligned, '0);
        chk_val("rst.valid", 128'(valid_out), 0);
        chk_val("rst.idx", 128'(row_idx), 0);
        chk_val("rst.done", 128'(done), 0);
        chk_val("rst.err", 128'(err_misalign), 0);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick(1'b1);
            chk_val($sformatf("post_rst.valid%0d", c), 128'(valid_out), 0);
        end

        // single row: visible only after enabled tick 3
        clr_sched();
        put_row(0, 32'h10);
        for (int c = 0; c < 8; c++) begin
            tick(1'b1);
            exp_out($sformatf("single%0d", c), c == 3, 32'h10, 0, 1'b0);
        end
        clear = 1'b1;
        tick(1'b0);
        clear = 1'b0;
        chk_val("clr1.idx", 128'(row_idx), 0);

        // full matrix, back to back
        clr_sched();
        for (int r = 0; r < 4; r++) put_row(r, 32'h40 + 32'(r * 16));
        for (int c = 0; c < 10; c++) begin
            tick(1'b1);
            exp_out($sformatf("full%0d", c), (c >= 3 && c <= 6),
                    32'h40 + 32'((c - 3) * 16), c - 3, c == 6);
        end

        // stall mid-matrix for 3 cycles, then once right after done
        clr_sched();
        for (int r = 0; r < 4; r++) put_row(r, 32'h80 + 32'(r * 16));
        for (int e = 0; e < 5; e++) begin
            tick(1'b1);
            exp_out($sformatf("stall_e%0d", e), e >= 3, 32'h80 + 32'((e - 3) * 16), e - 3, 1'b0);
        end
        for (int s = 0; s < 3; s++) begin
            tick(1'b0);
            exp_out($sformatf("stall_hold%0d", s), 1'b1, 32'h90, 1, 1'b0);
        end
        tick(1'b1);
        exp_out("stall_e5", 1'b1, 32'hA0, 2, 1'b0);
        tick(1'b1);
        exp_out("stall_e6", 1'b1, 32'hB0, 3, 1'b1);
        tick(1'b0);
        exp_out("stall_done_hold", 1'b1, 32'hB0, 3, 1'b0);
        tick(1'b1);
        exp_out("stall_e7", 1'b0, 32'h0, 0, 1'b0);

        // misalignment: lane 2 of the second row arrives a cycle early
        clr_sched();
        put_row(0, 32'hC0);
        for (int i = 0; i < MS; i++) begin
            if (i != 2) begin
                sd[2+i][i] = 32'hC8 + 32'(i);
                sv[2+i][i] = 1'b1;
            end
        end
        sd[3][2] = 32'hCA;
        sv[3][2] = 1'b1;
        put_row(6, 32'hD0);
        for (int e = 0; e < 11; e++) begin
            tick(1'b1);
            exp_out($sformatf("mis_e%0d", e), (e == 3 || e == 9),
                    (e == 3) ? 32'hC0 : 32'hD0, (e == 3) ? 0 : 1, 1'b0);
            chk_val($sformatf("mis_err%0d", e), 128'(err_misalign), 128'(e >= 4));
        end
        clear = 1'b1;
        tick(1'b0);
        clear = 1'b0;
        chk_val("clr2.err", 128'(err_misalign), 0);
        chk_val("clr2.idx", 128'(row_idx), 0);
        chk_val("clr2.valid", 128'(valid_out), 0);

        // clear coinciding with an accepted row: row shown but not counted
        put_row(11, 32'hE0);
        put_row(15, 32'hF0);
        put_row(19, 32'h100);
        for (int e = 11; e < 24; e++) begin
            clear = (e == 18);
            tick(1'b1);
            exp_out($sformatf("clrrow_e%0d", e), (e == 14 || e == 18 || e == 22),
                    (e == 14) ? 32'hE0 : ((e == 18) ? 32'hF0 : 32'h100), 0, 1'b0);
        end
        clear = 1'b0;
        chk_val("clrrow.err", 128'(err_misalign), 0);

        // async reset after two rows of a matrix, then a fresh matrix
        clear = 1'b1;
        tick(1'b0);
        clear = 1'b0;
        clr_sched();
        for (int r = 0; r < 4; r++) put_row(r, 32'h20 + 32'(r * 16));
        for (int e = 0; e < 5; e++) begin
            tick(1'b1);
            exp_out($sformatf("arst_e%0d", e), e >= 3, 32'h20 + 32'((e - 3) * 16), e - 3, 1'b0);
        end
        #2;
        reset = 1'b0;
        #1;
        chk_val("arst.data", data_aligned, '0);
        chk_val("arst.valid", 128'(valid_out), 0);
        chk_val("arst.idx", 128'(row_idx), 0);
        chk_val("arst.done", 128'(done), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_val("arst_hold.valid", 128'(valid_out), 0);
        reset = 1'b1;
        clr_sched();
        for (int r = 0; r < 4; r++) put_row(r, 32'h60 + 32'(r * 16));
        for (int e = 0; e < 8; e++) begin
            tick(1'b1);
            exp_out($sformatf("fresh_e%0d", e), (e >= 3 && e <= 6),
                    32'h60 + 32'((e - 3) * 16), e - 3, e == 6);
        end
        chk_val("fresh.err", 128'(err_misalign), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
